ram_sdp_be: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port and one read port on the same clock.
- Successor to the single-port ram block. Adds:
  - per-byte write enables
  - configurable read latency
  - selectable read-during-write collision mode
  - hardware clear sweep after reset
  - out-of-range address detection
- Sits behind ram_interface in the ram_pkg environment. Used as local buffer storage by datapath blocks.

---
 rtl/ram_sdp_be_pkg.sv | 25 ++
 rtl/ram_sdp_be_if.sv | 38 +++
 rtl/ram_sdp_be_rd_pipe.sv | 51 +++++
 rtl/ram_sdp_be.sv | 104 ++++++++++
 tb/tb_ram_sdp_be.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sdp_be_pkg.sv
`default_nettype none
// ============================================================================
// ram_sdp_be_pkg : shared types and helpers for the ram_sdp_be RAM family
// Revision 1.0 - initial release
// ============================================================================
package ram_sdp_be_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int byte_cnt(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sdp_be_if.sv
`default_nettype none
// ============================================================================
// ram_sdp_be_if : write/read request bundle of the ram_sdp_be RAM
// Revision 1.0 - initial release
// ============================================================================
interface ram_sdp_be_if
  import ram_sdp_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int NBYTES = byte_cnt(DATA_W);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NBYTES-1:0] wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, busy, addr_err
  );

endinterface
`default_nettype wire

// File: rtl/ram_sdp_be_rd_pipe.sv
`default_nettype none
// ============================================================================
// ram_sdp_be_rd_pipe : RD_LAT-deep data+valid delay line, data held when idle
// Revision 1.0 - initial release
// ============================================================================
module ram_sdp_be_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_valid,
  input  wire logic [DATA_W-1:0] i_data,
  output logic                   o_valid,
  output logic      [DATA_W-1:0] o_data
);

  logic              r_vld [RD_LAT];
  logic [DATA_W-1:0] r_dat [RD_LAT];

  for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
    logic              w_v_in;
    logic [DATA_W-1:0] w_d_in;

    if (s == 0) begin : g_head
      assign w_v_in = i_valid;
      assign w_d_in = i_data;
    end else begin : g_tail
      assign w_v_in = r_vld[s-1];
      assign w_d_in = r_dat[s-1];
    end

    // Data only moves with a valid token, so the last stage holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld[s] <= 1'b0;
        r_dat[s] <= '0;
      end else begin
        r_vld[s] <= w_v_in;
        if (w_v_in) begin
          r_dat[s] <= w_d_in;
        end
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_dat[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/ram_sdp_be.sv
`default_nettype none
// ============================================================================
// ram_sdp_be : simple-dual-port RAM, byte enables, clear sweep, RDW select
// Revision 1.0 - initial release
// ============================================================================
module ram_sdp_be
  import ram_sdp_be_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 16,
  parameter int                 RD_LAT   = 1,
  parameter int                 RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ram_sdp_be_if.slave bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int NBYTES = byte_cnt(DATA_W);

  ram_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_hit;
  logic [DATA_W-1:0] w_rd_word;

  assign w_ready = (r_state == READY);
  assign w_wr_in = (32'(bus.wr_addr) < 32'(DEPTH));
  assign w_rd_in = (32'(bus.rd_addr) < 32'(DEPTH));
  assign w_wr_ok = w_ready & bus.wr_en & w_wr_in;
  assign w_rd_ok = w_ready & bus.rd_en;
  assign w_hit   = w_wr_ok & w_rd_in & (bus.wr_addr == bus.rd_addr);

  // Out-of-range reads still return a token, carrying zero data.
  always_comb begin
    w_rd_word = w_rd_in ? r_mem[bus.rd_addr] : '0;
    if ((RDW_MODE == RDW_NEW) && w_hit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) begin
          w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  // Array has no reset; the sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) begin
          r_mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_ready & ((bus.wr_en & ~w_wr_in) | (bus.rd_en & ~w_rd_in));
      case (r_state)
        CLEAR: begin
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= READY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        READY: r_state <= READY;
      endcase
    end
  end

  assign bus.busy     = ~w_ready;
  assign bus.addr_err = r_addr_err;

  ram_sdp_be_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_ok),
    .i_data  (w_rd_word),
    .o_valid (bus.rd_valid),
    .o_data  (bus.rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_be.sv
`default_nettype none
// ============================================================================
// tb_ram_sdp_be : four ram_sdp_be configurations against a word-level model
// Revision 1.0 - initial release
// ============================================================================
module tb_ram_sdp_be;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          c_depth [4];
  int          c_lat   [4];
  int          c_rdw   [4];
  logic [31:0] c_init  [4];

  logic        s_wr_en [4];
  logic        s_rd_en [4];
  logic [3:0]  s_wr_addr [4];
  logic [3:0]  s_rd_addr [4];
  logic [3:0]  s_wr_be [4];
  logic [31:0] s_wr_data [4];
  logic        o_rd_valid [4];
  logic        o_busy [4];
  logic        o_addr_err [4];
  logic [31:0] o_rd_data [4];

  // Model: word array, sweep edges left, read results scheduled by due cycle.
  logic [31:0] m_mem [4][16];
  int          m_clear_left [4];
  logic        m_err [4];
  logic [31:0] m_last [4];
  logic        m_sv [4][4];
  logic [31:0] m_sd [4][4];

  ram_sdp_be_if #(.DATA_W(32), .DEPTH(16)) if0 ();
  ram_sdp_be_if #(.DATA_W(32), .DEPTH(16)) if1 ();
  ram_sdp_be_if #(.DATA_W(32), .DEPTH(16)) if2 ();
  ram_sdp_be_if #(.DATA_W(32), .DEPTH(12)) if3 ();

  ram_sdp_be #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(32'h0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  ram_sdp_be #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(1), .INIT_VAL(32'h0))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  ram_sdp_be #(.DATA_W(32), .DEPTH(16), .RD_LAT(3), .RDW_MODE(0), .INIT_VAL(32'h0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  ram_sdp_be #(.DATA_W(32), .DEPTH(12), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(32'hA5A5_0F0F))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.wr_en = s_wr_en[0];  assign if0.wr_addr = s_wr_addr[0];  assign if0.wr_data = s_wr_data[0];
  assign if0.wr_be = s_wr_be[0];  assign if0.rd_en = s_rd_en[0];      assign if0.rd_addr = s_rd_addr[0];
  assign if1.wr_en = s_wr_en[1];  assign if1.wr_addr = s_wr_addr[1];  assign if1.wr_data = s_wr_data[1];
  assign if1.wr_be = s_wr_be[1];  assign if1.rd_en = s_rd_en[1];      assign if1.rd_addr = s_rd_addr[1];
  assign if2.wr_en = s_wr_en[2];  assign if2.wr_addr = s_wr_addr[2];  assign if2.wr_data = s_wr_data[2];
  assign if2.wr_be = s_wr_be[2];  assign if2.rd_en = s_rd_en[2];      assign if2.rd_addr = s_rd_addr[2];
  assign if3.wr_en = s_wr_en[3];  assign if3.wr_addr = s_wr_addr[3];  assign if3.wr_data = s_wr_data[3];
  assign if3.wr_be = s_wr_be[3];  assign if3.rd_en = s_rd_en[3];      assign if3.rd_addr = s_rd_addr[3];

  assign o_rd_valid[0] = if0.rd_valid; assign o_rd_data[0] = if0.rd_data; assign o_busy[0] = if0.busy; assign o_addr_err[0] = if0.addr_err;
  assign o_rd_valid[1] = if1.rd_valid; assign o_rd_data[1] = if1.rd_data; assign o_busy[1] = if1.busy; assign o_addr_err[1] = if1.addr_err;
  assign o_rd_valid[2] = if2.rd_valid; assign o_rd_data[2] = if2.rd_data; assign o_busy[2] = if2.busy; assign o_addr_err[2] = if2.addr_err;
  assign o_rd_valid[3] = if3.rd_valid; assign o_rd_data[3] = if3.rd_data; assign o_busy[3] = if3.busy; assign o_addr_err[3] = if3.addr_err;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      s_wr_en[i] = 1'b0; s_rd_en[i] = 1'b0; s_wr_addr[i] = 4'd0;
      s_rd_addr[i] = 4'd0; s_wr_be[i] = 4'd0; s_wr_data[i] = 32'd0;
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) begin
      m_clear_left[i] = c_depth[i];
      m_err[i]        = 1'b0;
      m_last[i]       = 32'd0;
      for (int s = 0; s < 4; s++) m_sv[i][s] = 1'b0;
    end
  endtask

  task automatic rand_stim(input int i);
    s_wr_en[i]   = 1'($urandom_range(0, 1));
    s_rd_en[i]   = 1'($urandom_range(0, 1));
    s_wr_addr[i] = 4'($urandom_range(0, 15));
    s_rd_addr[i] = ($urandom_range(0, 3) == 0) ? s_wr_addr[i] : 4'($urandom_range(0, 15));
    s_wr_be[i]   = 4'($urandom_range(0, 15));
    s_wr_data[i] = $urandom;
  endtask

  // One clock: update the model with what was sampled, then score every output.
  task automatic tick();
    logic [31:0] rd;
    bit          in_w, in_r;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (m_clear_left[i] > 0) begin
        m_mem[i][c_depth[i] - m_clear_left[i]] = c_init[i];
        m_clear_left[i]--;
        m_err[i] = 1'b0;
      end else begin
        in_w = int'(s_wr_addr[i]) < c_depth[i];
        in_r = int'(s_rd_addr[i]) < c_depth[i];
        m_err[i] = (s_wr_en[i] && !in_w) || (s_rd_en[i] && !in_r);
        if (s_rd_en[i]) begin
          rd = in_r ? m_mem[i][s_rd_addr[i]] : 32'd0;
          if (c_rdw[i] == 1 && in_r && s_wr_en[i] && in_w && s_wr_addr[i] == s_rd_addr[i])
            rd = merge(rd, s_wr_data[i], s_wr_be[i]);
          m_sv[i][(cyc + c_lat[i] - 1) % 4] = 1'b1;
          m_sd[i][(cyc + c_lat[i] - 1) % 4] = rd;
        end
        if (s_wr_en[i] && in_w)
          m_mem[i][s_wr_addr[i]] = merge(m_mem[i][s_wr_addr[i]], s_wr_data[i], s_wr_be[i]);
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      logic ev;
      logic eb;
      ev = m_sv[i][cyc % 4];
      eb = (m_clear_left[i] > 0);
      if (ev) m_last[i] = m_sd[i][cyc % 4];
      m_sv[i][cyc % 4] = 1'b0;
      checks++;
      if (o_rd_valid[i] !== ev) begin
        errors++; $display("FAIL sb_rd_valid inst%0d cyc%0d got %b exp %b", i, cyc, o_rd_valid[i], ev);
      end
      checks++;
      if (o_rd_data[i] !== m_last[i]) begin
        errors++; $display("FAIL sb_rd_data inst%0d cyc%0d got %h exp %h", i, cyc, o_rd_data[i], m_last[i]);
      end
      checks++;
      if (o_addr_err[i] !== m_err[i]) begin
        errors++; $display("FAIL sb_addr_err inst%0d cyc%0d got %b exp %b", i, cyc, o_addr_err[i], m_err[i]);
      end
      checks++;
      if (o_busy[i] !== eb) begin
        errors++; $display("FAIL sb_busy inst%0d cyc%0d got %b exp %b", i, cyc, o_busy[i], eb);
      end
    end
  endtask

  task automatic do_write(input int i, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    s_wr_en[i] = 1'b1; s_wr_addr[i] = a; s_wr_data[i] = d; s_wr_be[i] = be;
    tick();
    s_wr_en[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [3:0] a);
    s_rd_en[i] = 1'b1; s_rd_addr[i] = a;
    tick();
    s_rd_en[i] = 1'b0;
    repeat (c_lat[i] - 1) tick();
  endtask

  task automatic test_reset();
    int fall [4];
    idle_all();
    #2 rst = 1'b1;
    mdl_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_rd_valid[i] !== 1'b0) begin errors++; $display("FAIL rst_rd_valid inst%0d got %b exp 0", i, o_rd_valid[i]); end
      checks++;
      if (o_rd_data[i] !== 32'd0) begin errors++; $display("FAIL rst_rd_data inst%0d got %h exp 0", i, o_rd_data[i]); end
      checks++;
      if (o_addr_err[i] !== 1'b0) begin errors++; $display("FAIL rst_addr_err inst%0d got %b exp 0", i, o_addr_err[i]); end
      checks++;
      if (o_busy[i] !== 1'b1) begin errors++; $display("FAIL rst_busy inst%0d got %b exp 1", i, o_busy[i]); end
      fall[i] = -1;
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int i = 0; i < 4; i++) if (fall[i] < 0 && o_busy[i] === 1'b0) fall[i] = k;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fall[i] != c_depth[i]) begin
        errors++; $display("FAIL busy_length inst%0d got %0d exp %0d", i, fall[i], c_depth[i]);
      end
    end
  endtask

  task automatic test_init_readback();
    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < c_depth[i]; a++) begin
        do_read(i, 4'(a));
        checks++;
        if (o_rd_valid[i] !== 1'b1 || o_rd_data[i] !== c_init[i]) begin
          errors++;
          $display("FAIL init_read inst%0d addr%0d got v=%b %h exp v=1 %h", i, a, o_rd_valid[i], o_rd_data[i], c_init[i]);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    do_write(0, 4'd3, 32'hDEAD_BEEF, 4'b1111);
    do_write(0, 4'd3, 32'h1122_3344, 4'b0101);
    do_read(0, 4'd3);
    checks++;
    if (o_rd_data[0] !== 32'hDE22_BE44) begin
      errors++; $display("FAIL byte_enable got %h exp DE22BE44", o_rd_data[0]);
    end
    do_write(0, 4'd3, 32'hFFFF_FFFF, 4'b0000);
    do_read(0, 4'd3);
    checks++;
    if (o_rd_data[0] !== 32'hDE22_BE44) begin
      errors++; $display("FAIL be_zero_noop got %h exp DE22BE44", o_rd_data[0]);
    end
  endtask

  task automatic test_collision();
    do_write(0, 4'd5, 32'hAAAA_AAAA, 4'b1111);
    do_write(1, 4'd5, 32'hAAAA_AAAA, 4'b1111);
    for (int i = 0; i < 2; i++) begin
      s_wr_en[i] = 1'b1; s_wr_addr[i] = 4'd5; s_wr_data[i] = 32'h1234_5678; s_wr_be[i] = 4'b0011;
      s_rd_en[i] = 1'b1; s_rd_addr[i] = 4'd5;
    end
    tick();
    idle_all();
    checks++;
    if (o_rd_data[0] !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL rdw_old got %h exp AAAAAAAA", o_rd_data[0]);
    end
    checks++;
    if (o_rd_data[1] !== 32'hAAAA_5678) begin
      errors++; $display("FAIL rdw_new got %h exp AAAA5678", o_rd_data[1]);
    end
    do_read(0, 4'd5);
    checks++;
    if (o_rd_data[0] !== 32'hAAAA_5678) begin
      errors++; $display("FAIL rdw_old_after got %h exp AAAA5678", o_rd_data[0]);
    end
  endtask

  task automatic test_latency3();
    logic ev;
    for (int a = 0; a < 4; a++) do_write(2, 4'(a), 32'h10 + 32'(a), 4'b1111);
    for (int k = 1; k <= 10; k++) begin
      s_rd_en[2] = (k <= 4);
      s_rd_addr[2] = 4'(k - 1);
      tick();
      ev = (k >= 3 && k <= 6);
      checks++;
      if (o_rd_valid[2] !== ev) begin
        errors++; $display("FAIL lat3_valid tick%0d got %b exp %b", k, o_rd_valid[2], ev);
      end
      if (ev) begin
        checks++;
        if (o_rd_data[2] !== 32'h10 + 32'(k - 3)) begin
          errors++; $display("FAIL lat3_data tick%0d got %h exp %h", k, o_rd_data[2], 32'h10 + 32'(k - 3));
        end
      end
    end
    idle_all();
  endtask

  task automatic test_out_of_range();
    do_write(3, 4'd1, 32'h0000_1111, 4'b1111);
    do_write(3, 4'd13, 32'h0000_00FF, 4'b1111);
    checks++;
    if (o_addr_err[3] !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", o_addr_err[3]); end
    tick();
    checks++;
    if (o_addr_err[3] !== 1'b0) begin errors++; $display("FAIL oor_pulse_end got %b exp 0", o_addr_err[3]); end
    s_wr_en[3] = 1'b1; s_wr_addr[3] = 4'd14; s_wr_data[3] = 32'hFFFF_FFFF; s_wr_be[3] = 4'b1111;
    s_rd_en[3] = 1'b1; s_rd_addr[3] = 4'd13;
    tick();
    idle_all();
    checks++;
    if (o_addr_err[3] !== 1'b1) begin errors++; $display("FAIL oor_both_err got %b exp 1", o_addr_err[3]); end
    tick();
    checks++;
    if (o_addr_err[3] !== 1'b0) begin errors++; $display("FAIL oor_single_pulse got %b exp 0", o_addr_err[3]); end
    checks++;
    if (o_rd_valid[3] !== 1'b1 || o_rd_data[3] !== 32'd0) begin
      errors++; $display("FAIL oor_read got v=%b %h exp v=1 0", o_rd_valid[3], o_rd_data[3]);
    end
    do_read(3, 4'd1);
    checks++;
    if (o_rd_data[3] !== 32'h0000_1111) begin
      errors++; $display("FAIL oor_no_alias got %h exp 00001111", o_rd_data[3]);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) rand_stim(i);
      tick();
    end
    idle_all();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_sweep();
    int fall [4];
    #2 rst = 1'b1;
    mdl_reset();
    #2 rst = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    mdl_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_busy[i] !== 1'b1 || o_rd_valid[i] !== 1'b0) begin
        errors++; $display("FAIL mid_rst_state inst%0d got busy=%b v=%b exp busy=1 v=0", i, o_busy[i], o_rd_valid[i]);
      end
      fall[i] = -1;
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 12) for (int i = 0; i < 4; i++) rand_stim(i);
      else idle_all();
      tick();
      for (int i = 0; i < 4; i++) if (fall[i] < 0 && o_busy[i] === 1'b0) fall[i] = k;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fall[i] != c_depth[i]) begin
        errors++; $display("FAIL mid_busy_length inst%0d got %0d exp %0d", i, fall[i], c_depth[i]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      do_read(0, 4'(a));
      checks++;
      if (o_rd_data[0] !== 32'd0) begin
        errors++; $display("FAIL mid_clear_read addr%0d got %h exp 0", a, o_rd_data[0]);
      end
    end
  endtask

  initial begin
    c_depth = '{16, 16, 16, 12};
    c_lat   = '{1, 1, 3, 2};
    c_rdw   = '{0, 1, 0, 1};
    c_init  = '{32'h0, 32'h0, 32'h0, 32'hA5A5_0F0F};
    idle_all();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_init_readback();
    test_byte_enable();
    test_collision();
    test_latency3();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
